// File: rtl/ras_request_gen_pkg.sv
// Shared types for the RAS request generator.
// Control-flow classes, FSM states and the link-register hint.
package ras_request_gen_pkg;

  typedef enum logic [1:0] {
    CF_BRANCH = 2'd0,
    CF_JAL    = 2'd1,
    CF_JALR   = 2'd2
  } cf_type_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } ras_req_state_t;

  // x1 (ra) and x5 (t0) are the RISC-V link registers
  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) | (r == 5'd5);
  endfunction

endpackage

// File: rtl/ras_request_gen_cf_decode.sv
// RAS hint decode for one control-flow instruction.
// Pure combinational: type/rd/rs1 to push/pop.
module ras_cf_decode
  import ras_request_gen_pkg::*;
(
  input  logic [1:0] cf_type_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  output logic       push_o,
  output logic       pop_o
);

  logic rd_link;
  logic rs1_link;

  assign rd_link  = is_link_reg(rd_i);
  assign rs1_link = is_link_reg(rs1_i);

  // Classify call / return / coroutine swap; reserved type is a branch
  always_comb begin
    push_o = 1'b0;
    pop_o  = 1'b0;
    unique case (1'b1)
      (cf_type_i == CF_JAL): begin
        push_o = rd_link;
      end
      (cf_type_i == CF_JALR): begin
        push_o = rd_link;
        pop_o  = rs1_link & ~(rd_link & (rd_i == rs1_i));
      end
      default: begin
        push_o = 1'b0;
        pop_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ras_request_gen.sv
// Fetch-side initiator of all return-address-stack requests.
// Tracks speculative checkpoints and holds fetch when full or recovering.
module ras_request_gen
  import ras_request_gen_pkg::*;
#(
  parameter  int MAX_BRANCHES = 8,
  localparam int CNT_W = $clog2(MAX_BRANCHES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gc_fetch_flush,
  input  logic             early_branch_flush,
  input  logic             cf_valid,
  input  logic [1:0]       cf_type,
  input  logic [4:0]       cf_rd,
  input  logic [4:0]       cf_rs1,
  input  logic [31:0]      cf_pc,
  input  logic             cf_compressed,
  input  logic             cf_speculative,
  input  logic             retire_branch,
  output logic             fetch_hold,
  output logic             ras_push,
  output logic             ras_pop,
  output logic [31:0]      ras_new_addr,
  output logic             ras_branch_fetched,
  output logic             ras_branch_retired,
  output logic [CNT_W-1:0] outstanding
);

  ras_req_state_t   state_q;
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] outstanding_d;

  logic flush;
  logic accept;
  logic dec_push;
  logic dec_pop;
  logic full;

  ras_cf_decode u_decode (
    .cf_type_i (cf_type),
    .rd_i      (cf_rd),
    .rs1_i     (cf_rs1),
    .push_o    (dec_push),
    .pop_o     (dec_pop)
  );

  assign flush  = gc_fetch_flush | early_branch_flush;
  assign full   = (outstanding_q == CNT_W'(MAX_BRANCHES));

  // Hold is conservative: a same-cycle retire does not release it
  assign fetch_hold = (state_q == RECOVER) | full;
  assign accept     = cf_valid & ~fetch_hold;

  // Requests still fire alongside a flush; the RAS restores on flush
  assign ras_push = accept & dec_push;
  assign ras_pop  = accept & dec_pop;

  assign ras_new_addr = ras_push
    ? cf_pc + (cf_compressed ? 32'd2 : 32'd4)
    : 32'd0;

  assign ras_branch_fetched = accept & cf_speculative;

  // Retires at zero belong to branches wiped by an earlier flush
  assign ras_branch_retired = retire_branch
    & (outstanding_q != '0)
    & (state_q == RUN);

  assign outstanding = outstanding_q;

  // Checkpoint count: cleared by flush, otherwise fetched minus retired
  always_comb begin
    outstanding_d = outstanding_q;
    if (flush || state_q == RECOVER) begin
      outstanding_d = '0;
    end else begin
      outstanding_d = outstanding_q
        + CNT_W'(ras_branch_fetched)
        - CNT_W'(ras_branch_retired);
    end
  end

  // RUN/RECOVER sequencing and counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      unique case (state_q)
        RUN:     state_q <= flush ? RECOVER : RUN;
        RECOVER: state_q <= flush ? RECOVER : RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ras_request_gen.sv
// Self-checking bench for ras_request_gen.
// Directed scenarios plus random traffic against a behavioural model.
module tb_ras_request_gen;

  logic        clk;
  logic        rst;
  logic        gc_fetch_flush;
  logic        early_branch_flush;
  logic        cf_valid;
  logic [1:0]  cf_type;
  logic [4:0]  cf_rd;
  logic [4:0]  cf_rs1;
  logic [31:0] cf_pc;
  logic        cf_compressed;
  logic        cf_speculative;
  logic        retire_branch;
  logic        fetch_hold;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] ras_new_addr;
  logic        ras_branch_fetched;
  logic        ras_branch_retired;
  logic [3:0]  outstanding;

  ras_request_gen dut (
    .clk                (clk),
    .rst                (rst),
    .gc_fetch_flush     (gc_fetch_flush),
    .early_branch_flush (early_branch_flush),
    .cf_valid           (cf_valid),
    .cf_type            (cf_type),
    .cf_rd              (cf_rd),
    .cf_rs1             (cf_rs1),
    .cf_pc              (cf_pc),
    .cf_compressed      (cf_compressed),
    .cf_speculative     (cf_speculative),
    .retire_branch      (retire_branch),
    .fetch_hold         (fetch_hold),
    .ras_push           (ras_push),
    .ras_pop            (ras_pop),
    .ras_new_addr       (ras_new_addr),
    .ras_branch_fetched (ras_branch_fetched),
    .ras_branch_retired (ras_branch_retired),
    .outstanding        (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // model state: count of live checkpoints and recovery flag
  int m_cnt;
  bit m_rec;
  int n_cnt;
  bit n_rec;
  logic [40:0] exp_vec;
  logic [40:0] got;

  assign got = {fetch_hold, ras_push, ras_pop, ras_new_addr,
                ras_branch_fetched, ras_branch_retired, outstanding};

  function automatic bit link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  task automatic calc_exp();
    bit hold, acc, lr, ls, p, q, f, r;
    logic [31:0] a;
    hold = m_rec || (m_cnt == 8);
    acc  = cf_valid && !hold;
    lr   = link(cf_rd);
    ls   = link(cf_rs1);
    p = 0;
    q = 0;
    if (acc && cf_type == 2'd1) p = lr;
    if (acc && cf_type == 2'd2) begin
      p = lr;
      // return when only rs1 links; swap when both link and differ
      q = ls && !(lr && cf_rd == cf_rs1);
    end
    a = p ? cf_pc + (cf_compressed ? 32'd2 : 32'd4) : 32'd0;
    f = acc && cf_speculative;
    r = retire_branch && (m_cnt != 0) && !m_rec;
    exp_vec = {hold, p, q, a, f, r, 4'(m_cnt)};
    if (rst) begin
      n_cnt = 0;
      n_rec = 0;
    end else if (gc_fetch_flush || early_branch_flush) begin
      n_cnt = 0;
      n_rec = 1;
    end else begin
      n_cnt = m_cnt + int'(f) - int'(r);
      n_rec = 0;
    end
  endtask

  task automatic tick();
    calc_exp();
    @(posedge clk);
    m_cnt = n_cnt;
    m_rec = n_rec;
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] t,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [31:0] pc, input bit c,
                       input bit s, input bit r,
                       input bit gc, input bit eb);
    cf_valid           = v;
    cf_type            = t;
    cf_rd              = rd;
    cf_rs1             = rs1;
    cf_pc              = pc;
    cf_compressed      = c;
    cf_speculative     = s;
    retire_branch      = r;
    gc_fetch_flush     = gc;
    early_branch_flush = eb;
  endtask

  task automatic idle();
    drive(0, 2'd0, 5'd0, 5'd0, 32'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    tick();
    tick();
    rst = 0;
    #1;
    n_checks++;
    if (got !== 41'd0) begin
      n_fail++;
      $display("FAIL reset: got %h required %h", got, 41'd0);
    end
    calc_exp();
    n_checks++;
    if (got !== exp_vec) begin
      n_fail++;
      $display("FAIL reset_model: got %h required %h", got, exp_vec);
    end
  endtask

  task automatic test_decode();
    logic [1:0]  tt [5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1};
    logic [4:0]  rd [5] = '{5'd1, 5'd0, 5'd1, 5'd1, 5'd5};
    logic [4:0]  rs [5] = '{5'd0, 5'd5, 5'd5, 5'd1, 5'd0};
    logic [31:0] pc [5] = '{32'h1000, 32'h0, 32'h2002, 32'h40,
                            32'hFFFF_FFFC};
    bit          cc [5] = '{0, 0, 1, 0, 0};
    bit          ep [5] = '{1, 0, 1, 1, 1};
    bit          eo [5] = '{0, 1, 1, 0, 0};
    logic [31:0] ea [5] = '{32'h1004, 32'h0, 32'h2004, 32'h44, 32'h0};
    logic [4:0]  regs [4] = '{5'd0, 5'd1, 5'd5, 5'd2};
    for (int i = 0; i < 5; i++) begin
      drive(1, tt[i], rd[i], rs[i], pc[i], cc[i], 0, 0, 0, 0);
      #1;
      n_checks++;
      if ({ras_push, ras_pop, ras_new_addr} !== {ep[i], eo[i], ea[i]}) begin
        n_fail++;
        $display("FAIL decode_dir[%0d]: got %b %b %h required %b %b %h",
                 i, ras_push, ras_pop, ras_new_addr, ep[i], eo[i], ea[i]);
      end
      tick();
    end
    for (int i = 0; i < 60; i++) begin
      drive(1, 2'($urandom_range(0, 3)),
            regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
            $urandom, 1'($urandom), 0, 0, 0, 0);
      #1;
      calc_exp();
      n_checks++;
      if (got !== exp_vec) begin
        n_fail++;
        $display("FAIL decode_rand[%0d]: got %h required %h",
                 i, got, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_capacity();
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom),
            $urandom, 1'($urandom), 1, 0, 0, 0);
      #1;
      calc_exp();
      n_checks++;
      if (got !== exp_vec) begin
        n_fail++;
        $display("FAIL cap_fill[%0d]: got %h required %h",
                 i, got, exp_vec);
      end
      tick();
    end
    drive(1, 2'd1, 5'd1, 5'd0, 32'h500, 0, 1, 0, 0, 0);
    #1;
    n_checks++;
    if ({outstanding, fetch_hold, ras_push, ras_pop, ras_branch_fetched}
        !== {4'd8, 4'b1000}) begin
      n_fail++;
      $display("FAIL cap_full: got cnt=%0d hold=%b push=%b pop=%b fet=%b",
               outstanding, fetch_hold, ras_push, ras_pop,
               ras_branch_fetched);
    end
    tick();
    drive(0, 2'd0, 5'd0, 5'd0, 32'd0, 0, 0, 1, 0, 0);
    #1;
    n_checks++;
    if (ras_branch_retired !== 1'b1 || fetch_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_retire: got ret=%b hold=%b required 1 1",
               ras_branch_retired, fetch_hold);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (outstanding !== 4'd7 || fetch_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL cap_release: got cnt=%0d hold=%b required 7 0",
               outstanding, fetch_hold);
    end
  endtask

  task automatic test_fetch_retire();
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'd0, 5'd0, 5'd0, 32'd0, 0, 0, 1, 0, 0);
      tick();
    end
    drive(1, 2'd0, 5'd0, 5'd0, 32'h80, 0, 1, 1, 0, 0);
    #1;
    n_checks++;
    if ({outstanding, ras_branch_fetched, ras_branch_retired}
        !== {4'd3, 2'b11}) begin
      n_fail++;
      $display("FAIL same_cycle: got cnt=%0d fet=%b ret=%b required 3 1 1",
               outstanding, ras_branch_fetched, ras_branch_retired);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (outstanding !== 4'd3) begin
      n_fail++;
      $display("FAIL same_cycle_cnt: got %0d required 3", outstanding);
    end
  endtask

  task automatic test_flush();
    drive(1, 2'd0, 5'd0, 5'd0, 32'h90, 0, 1, 0, 0, 0);
    tick();
    drive(1, 2'd1, 5'd1, 5'd0, 32'h3000, 0, 1, 0, 1, 0);
    #1;
    n_checks++;
    if ({outstanding, ras_push, ras_branch_fetched, ras_new_addr}
        !== {4'd4, 2'b11, 32'h3004}) begin
      n_fail++;
      $display("FAIL flush_emit: got cnt=%0d push=%b fet=%b addr=%h",
               outstanding, ras_push, ras_branch_fetched, ras_new_addr);
    end
    tick();
    drive(1, 2'd1, 5'd1, 5'd0, 32'h3000, 0, 1, 1, 0, 0);
    #1;
    n_checks++;
    if ({fetch_hold, outstanding, ras_push, ras_branch_fetched,
         ras_branch_retired} !== {1'b1, 4'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL flush_recover: got hold=%b cnt=%0d push=%b fet=%b",
               fetch_hold, outstanding, ras_push, ras_branch_fetched);
    end
    tick();
    drive(0, 2'd0, 5'd0, 5'd0, 32'd0, 0, 0, 1, 0, 0);
    #1;
    n_checks++;
    if ({fetch_hold, ras_branch_retired, outstanding} !== 6'd0) begin
      n_fail++;
      $display("FAIL flush_resume: got hold=%b ret=%b cnt=%0d required 0",
               fetch_hold, ras_branch_retired, outstanding);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'd0, 5'd0, 5'd0, 32'h100, 0, 1, 0, 0, 0);
      tick();
    end
    drive(0, 2'd0, 5'd0, 5'd0, 32'd0, 0, 0, 0, 0, 1);
    #1;
    n_checks++;
    if (outstanding !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_count: got %0d required 5", outstanding);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'd1, 5'd1, 5'd0, 32'h200, 0, 1, 0, 0, i == 0);
      #1;
      calc_exp();
      n_checks++;
      if (got !== exp_vec || fetch_hold !== (i < 2)) begin
        n_fail++;
        $display("FAIL double_flush[%0d]: got %h required %h",
                 i, got, exp_vec);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'd0, 5'd0, 5'd0, 32'h100, 0, 1, 0, 0, 0);
      tick();
    end
    rst = 1;
    drive(1, 2'd1, 5'd1, 5'd0, 32'h300, 0, 1, 1, 0, 1);
    tick();
    rst = 0;
    idle();
    #1;
    n_checks++;
    if (got !== 41'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h required 0", got);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] regs [4] = '{5'd0, 5'd1, 5'd5, 5'd7};
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
            regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
            $urandom, 1'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
      #1;
      calc_exp();
      n_checks++;
      if (got !== exp_vec) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h required %h",
                 i, got, exp_vec);
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_cnt    = 0;
    m_rec    = 0;
    rst      = 1;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_decode();
    test_capacity();
    test_fetch_retire();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ras_request_gen.md
Name: ras_request_gen

Overview:
- Fetch-side driver of the return-address-stack interface: the initiator that generates every RAS request.
- Classifies each accepted control-flow instruction as call, return, coroutine swap or plain branch, using the RISC-V link-register hint rules.
- Drives push, pop, new_addr, branch_fetched and branch_retired toward the RAS.
- Tracks in-flight speculative branches so that checkpoint pops never exceed checkpoint pushes, and holds fetch while checkpoint storage is full or recovering.

Parameters:
- MAX_BRANCHES, 8: maximum outstanding speculative branches; equals the RAS checkpoint FIFO depth (MAX_IDS).
- CNT_W, $clog2(MAX_BRANCHES+1): width of the outstanding counter. Derived; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- gc_fetch_flush  in  1  global fetch flush (mispredict/exception)
- early_branch_flush  in  1  early-resolve redirect; also resets RAS checkpoints
- cf_valid  in  1  control-flow instruction accepted by fetch this cycle
- cf_type  in  2  0=BRANCH, 1=JAL, 2=JALR, 3=reserved (treat as BRANCH)
- cf_rd  in  5  destination register
- cf_rs1  in  5  source register (JALR only)
- cf_pc  in  32  instruction PC
- cf_compressed  in  1  16-bit encoding
- cf_speculative  in  1  outcome unresolved; needs a checkpoint
- retire_branch  in  1  a speculative branch resolved/retired
- fetch_hold  out  1  fetch must not present a new cf_valid
- ras_push  out  1  RAS push
- ras_pop  out  1  RAS pop
- ras_new_addr  out  32  return address to push
- ras_branch_fetched  out  1  save RAS pointer checkpoint
- ras_branch_retired  out  1  release oldest checkpoint
- outstanding  out  CNT_W  current checkpoint count

Behaviour:
- Request qualification:
  - link(r) = (r==1) | (r==5).
  - accept = cf_valid & ~fetch_hold. When accept is low, all request outputs are 0 and cf_valid has no effect.
- Decode (combinational, same cycle as accept):
  - JAL: push = link(rd).
  - JALR:
    - !link(rd) & link(rs1): pop.
    - link(rd) & !link(rs1): push.
    - link(rd) & link(rs1) & rd!=rs1: pop and push both asserted (coroutine).
    - link(rd) & link(rs1) & rd==rs1: push only.
  - BRANCH/reserved: neither push nor pop.
- Return address: ras_new_addr = cf_pc + (cf_compressed ? 2 : 4), modulo 2^32, valid whenever ras_push=1. Output 0 when ras_push=0.
- ras_branch_fetched = accept & cf_speculative.
- ras_branch_retired = retire_branch & (outstanding != 0) & state==RUN. Retirements at count 0 belong to pre-flush branches and are dropped silently.
- Counter update, next outstanding = outstanding + fetched - retired. Simultaneous fetch and retire leaves it unchanged. Never wraps, never underflows.
- FSM, states RUN and RECOVER:
  - RUN -> RECOVER on gc_fetch_flush | early_branch_flush; outstanding <= 0 on that same edge.
  - RECOVER -> RUN after exactly 1 cycle unless a flush is asserted again, in which case it stays in RECOVER.
  - In RECOVER: all request outputs are 0 and fetch_hold=1.
- Flush priority: a flush in the same cycle as accept still emits that cycle's push/pop/fetched, because the RAS restores its pointer on flush. The counter is nevertheless cleared.
- fetch_hold = (state==RECOVER) | (outstanding == MAX_BRANCHES). This is conservative: a retire in the same cycle does not release the hold.
- Reset values: state=RUN, outstanding=0. Consequently fetch_hold=0 and all request outputs=0.
- Latency: requests are combinational from inputs (0 cycles); counter, state and hold take effect on the next edge.

Decomposition:
- Shared package, cva5_types: typedef cf_type_t enum {CF_BRANCH, CF_JAL, CF_JALR}; typedef ras_req_state_t {RUN, RECOVER}.
- Helper function is_link_reg(logic[4:0]) belongs in riscv_types.
- Sub-module: ras_cf_decode, purely combinational (type/rd/rs1 to push/pop). The counter and FSM stay in the top module.

Test Plan:
- JAL rd=1, pc=0x1000, compressed=0 -> push=1, new_addr=0x1004, pop=0, same cycle. JALR rd=0 rs1=5 -> pop=1 only.
- C.JALR rd=1 rs1=5, pc=0x2002, compressed=1 -> push=1 and pop=1 together, new_addr=0x2004. rd=rs1=1 -> push only. pc=0xFFFFFFFC, compressed=0 -> new_addr=0x00000000.
- 8 speculative branches with no retire -> outstanding=8, fetch_hold=1. A 9th cf_valid produces no outputs. One retire -> outstanding=7, hold drops the next cycle.
- Same-cycle speculative fetch and retire at outstanding=3 -> fetched=1, retired=1, outstanding stays 3.
- outstanding=4, assert gc_fetch_flush -> next cycle state=RECOVER, outstanding=0, hold=1, cf_valid ignored. RUN resumes the following cycle. A retire_branch at count 0 -> ras_branch_retired=0.
- Reset asserted mid-sequence with outstanding=5 and a back-to-back early_branch_flush -> after reset: outstanding=0, RUN, all outputs 0. Two consecutive flushes keep RECOVER for 2 cycles.
